csr_excp_ctrl: RTL
==================

// Module: csr_excp_ctrl
// PURPOSE
//  Commit-side responder to the WB exception interface. Consumes excp_flush/ertn_flush/ecode/esubcode/era/badv from WB.
//  Owns the exception CSRs CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TLBRENTRY, TCFG, TVAL and TICLR.
//  Produces the registered fetch redirect plus the interrupt-pending level that WB/MEM fold into ms_excp.
// PARAMETERS
//  RESET_EENTRY     32'h0000_0000  EENTRY reset value
//  RESET_TLBRENTRY  32'h0000_0000  TLBRENTRY reset value
// PORTS
//  clk             in   1   single clock
//  reset           in   1   asynchronous, active-low reset
//  excp_flush      in   1   exception commit strobe from WB
//  ertn_flush      in   1   ertn commit strobe from WB
//  excp_era        in   32  PC of the committing instruction
//  ecode           in   6   exception code
//  esubcode        in   9   exception subcode
//  badv            in   32  faulting address
//  badv_valid      in   1   badv is meaningful this commit
//  csr_we          in   1   CSR write from the csrwr/csrxchg commit
//  csr_waddr       in   14  CSR write address
//  csr_wdata       in   32  CSR write data
//  csr_wmask       in   32  per-bit write mask (all ones for csrwr)
//  csr_raddr       in   14  CSR read address
//  csr_rdata       out  32  combinational read data; 0 for unimplemented addresses
//  hw_int          in   8   level hardware interrupts, land in ESTAT.IS[9:2]
//  ipi             in   1   inter-processor interrupt, lands in ESTAT.IS[12]
//  redirect_valid  out  1   one-cycle fetch redirect pulse
//  redirect_pc     out  32  redirect target
//  int_pending     out  1   CRMD.IE & |(ESTAT.IS & ECFG.LIE)
//  crmd_plv        out  2   current privilege level
//  crmd_da_pg      out  2   {DA,PG} for the MMU
// BEHAVIOUR
//  - Reset values: CRMD={DA=1,PG=0,IE=0,PLV=0}. All other CSRs are 0 except EENTRY/TLBRENTRY, which take their parameters.
//    Outputs at reset: redirect_valid=0, redirect_pc=0, int_pending=0.
//  - excp_flush (sampled at posedge):
//    - PRMD.{PPLV,PIE} <= CRMD.{PLV,IE}; CRMD.{PLV,IE} <= 0.
//    - ERA <= excp_era; ESTAT.{Ecode,EsubCode} <= {ecode,esubcode}.
//    - BADV <= badv only when badv_valid.
//    - ecode==ECODE_TLBR: CRMD.{DA,PG} <= 2'b10; target = TLBRENTRY. Otherwise target = EENTRY.
//  - ertn_flush:
//    - CRMD.{PLV,IE} <= PRMD.{PPLV,PIE}; target = ERA.
//    - If ESTAT.Ecode==ECODE_TLBR: CRMD.{DA,PG} <= 2'b01.
//  - Redirect latency: redirect_valid=1 exactly one cycle after the strobe, with redirect_pc=target. It is 0 otherwise.
//  - Simultaneous events:
//    - excp_flush and ertn_flush together: excp wins, ertn is dropped.
//    - Any flush suppresses csr_we in that cycle entirely (no partial write).
//  - CSR write: reg <= (reg & ~mask) | (wdata & mask), restricted to writable fields. Read-only fields and ESTAT.IS[12:2] ignore writes.
//    - A TCFG write also loads TVAL <= {InitVal[31:2],2'b00}.
//    - A TICLR write with wdata[0]=1 clears ESTAT.IS[11]; TICLR always reads 0.
//  - Timer (TCFG={InitVal,Periodic,En}), evaluated every cycle when En=1:
//    - TVAL!=0: TVAL decrements by 1. On the 1->0 step, ESTAT.IS[11] <= 1.
//    - TVAL==0 & Periodic: reload {InitVal,2'b00}. TVAL==0 & !Periodic: hold at 0 (no re-fire).
//    - A TCFG write in the same cycle overrides the decrement. A simultaneous timer fire and TICLR clear resolves to clear.
//  - ESTAT.IS[9:2] <= hw_int and IS[12] <= ipi every cycle (registered, 1-cycle sampling delay).
//  - int_pending is combinational from registered state.
//  - Reset mid-operation: all state returns to reset values immediately; a pending redirect is lost.
// CONFIGURATION
//  - CSR_SOFT_INT_EN defined:
//    - ESTAT.IS[1:0] is software-writable via the mask write.
//    - IS[1:0] participate in int_pending.
//  - CSR_SOFT_INT_EN undefined:
//    - IS[1:0] read 0 and ignore writes.
//    - Only IS[12:2] can raise int_pending.
// STRUCTURE
//  - CSR addresses, field offsets and ECODE_*/ESUBCODE_* constants come from the shared csr_defines.v.
//    No new literals appear in this file.
//  - One sub-module, csr_timer: owns TCFG/TVAL and emits a timer_fire pulse.
//    It takes tcfg_we/tcfg_wdata as inputs; TICLR and ESTAT.IS[11] stay in the parent.
// TESTING
//  1. Reset, then read CRMD -> 32'h0000_0008; redirect_valid=0; int_pending=0.
//  2. EENTRY=32'h1C00_8000, PLV=3, IE=1, then excp_flush with ecode=SYS, era=32'h1C00_0100:
//     - next cycle: redirect_pc=32'h1C00_8000.
//     - ERA=32'h1C00_0100; PRMD.PPLV=3, PIE=1; CRMD.PLV=0, IE=0; BADV unchanged.
//  3. excp_flush with ecode=TLBR, badv=32'hDEAD_B000, badv_valid=1, then ertn_flush:
//     - first redirect = TLBRENTRY; CRMD.{DA,PG}=10; BADV=32'hDEAD_B000.
//     - after ertn: redirect = ERA; CRMD.{DA,PG}=01.
//  4. TCFG={InitVal=1,Periodic=0,En=1}, then IE=1, LIE[11]=1:
//     - IS[11] sets after 4 decrements; int_pending=1; TVAL holds 0.
//     - TICLR wdata=1 -> IS[11]=0, int_pending=0.
//  5. Same cycle excp_flush + ertn_flush + csr_we to ERA:
//     - excp path taken: ERA=excp_era, redirect = EENTRY, CSR write ignored.
//  6. With CSR_SOFT_INT_EN: write ESTAT IS[0]=1, LIE[0]=1, IE=1 -> int_pending=1.
//     Without it: same sequence -> IS[0] reads 0, int_pending=0.

Source files
------------

// File: rtl/csr_excp_ctrl_pkg.sv
// Shared CSR addresses, field offsets, write masks and exception codes for the
// exception/interrupt CSR block, plus the masked-write merge helper.
package csr_excp_ctrl_pkg;

   localparam logic [13:0] CSR_CRMD      = 14'h000;
   localparam logic [13:0] CSR_PRMD      = 14'h001;
   localparam logic [13:0] CSR_ECFG      = 14'h004;
   localparam logic [13:0] CSR_ESTAT     = 14'h005;
   localparam logic [13:0] CSR_ERA       = 14'h006;
   localparam logic [13:0] CSR_BADV      = 14'h007;
   localparam logic [13:0] CSR_EENTRY    = 14'h00C;
   localparam logic [13:0] CSR_TCFG      = 14'h041;
   localparam logic [13:0] CSR_TVAL      = 14'h042;
   localparam logic [13:0] CSR_TICLR     = 14'h044;
   localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

   localparam logic [5:0]  ECODE_TLBR    = 6'h3F;

   localparam int CRMD_PLV       = 0;
   localparam int CRMD_IE        = 2;
   localparam int CRMD_DA        = 3;
   localparam int CRMD_PG        = 4;
   localparam int PRMD_PPLV      = 0;
   localparam int PRMD_PIE       = 2;
   localparam int ESTAT_IS_SW    = 0;
   localparam int ESTAT_IS_HW    = 2;
   localparam int ESTAT_IS_TI    = 11;
   localparam int ESTAT_IS_IPI   = 12;
   localparam int ESTAT_IS_W     = 13;
   localparam int ESTAT_ECODE    = 16;
   localparam int ESTAT_ESUBCODE = 22;
   localparam int TCFG_EN        = 0;
   localparam int TCFG_PERIODIC  = 1;
   localparam int TICLR_CLR      = 0;

   localparam logic [31:0] CRMD_RESET      = 32'h0000_0008;
   localparam logic [31:0] CRMD_WMASK      = 32'h0000_001F;
   localparam logic [31:0] PRMD_WMASK      = 32'h0000_0007;
   localparam logic [31:0] ECFG_WMASK      = 32'h0000_1BFF;
   localparam logic [31:0] ENTRY_WMASK     = 32'hFFFF_FFC0;

   function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [31:0] mask);
      return (old_v & ~mask) | (wdata & mask);
   endfunction

endpackage

// File: rtl/csr_excp_ctrl_timer.sv
// Countdown timer owning TCFG/TVAL; pulses o_timer_fire on the 1->0 step.
// Interrupt-status bookkeeping (IS[11], TICLR) lives in the parent.
module csr_excp_ctrl_timer
   import csr_excp_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_tcfg_we,
   input  logic [31:0] i_tcfg_wdata,
   output logic [31:0] o_tcfg,
   output logic [31:0] o_tval,
   output logic        o_timer_fire
);

   logic [31:0] r_tcfg;
   logic [31:0] r_tval;

   // A TCFG write in the same cycle takes the place of the decrement, so no fire then.
   assign o_timer_fire = ~i_tcfg_we & r_tcfg[TCFG_EN] & (r_tval == 32'd1);
   assign o_tcfg       = r_tcfg;
   assign o_tval       = r_tval;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tcfg <= '0;
         r_tval <= '0;
      end else if (i_tcfg_we) begin
         r_tcfg <= i_tcfg_wdata;
         r_tval <= {i_tcfg_wdata[31:2], 2'b00};
      end else if (r_tcfg[TCFG_EN]) begin
         if (r_tval != '0) begin
            r_tval <= r_tval - 32'd1;
         end else if (r_tcfg[TCFG_PERIODIC]) begin
            r_tval <= {r_tcfg[31:2], 2'b00};
         end
      end
   end

endmodule

// File: rtl/csr_excp_ctrl.sv
// Commit-side exception/interrupt CSR block: handles WB exception and ertn commits,
// owns the exception CSRs and drives a registered fetch redirect. Build option: CSR_SOFT_INT_EN.
module csr_excp_ctrl
   import csr_excp_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_EENTRY    = 32'h0000_0000,
   parameter logic [31:0] RESET_TLBRENTRY = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        excp_flush,
   input  logic        ertn_flush,
   input  logic [31:0] excp_era,
   input  logic [5:0]  ecode,
   input  logic [8:0]  esubcode,
   input  logic [31:0] badv,
   input  logic        badv_valid,
   input  logic        csr_we,
   input  logic [13:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] csr_wmask,
   input  logic [13:0] csr_raddr,
   output logic [31:0] csr_rdata,
   input  logic [7:0]  hw_int,
   input  logic        ipi,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        int_pending,
   output logic [1:0]  crmd_plv,
   output logic [1:0]  crmd_da_pg
);

   logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_badv, r_eentry, r_tlbrentry;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   logic        w_any_flush, w_we, w_tcfg_we, w_ticlr, w_timer_fire;
   logic [31:0] w_tcfg, w_tval, w_tcfg_wdata;

   // Any commit flush kills the CSR write of the same cycle outright.
   assign w_any_flush  = excp_flush | ertn_flush;
   assign w_we         = csr_we & ~w_any_flush;
   assign w_tcfg_we    = w_we & (csr_waddr == CSR_TCFG);
   assign w_ticlr      = w_we & (csr_waddr == CSR_TICLR) & csr_wdata[TICLR_CLR] & csr_wmask[TICLR_CLR];
   assign w_tcfg_wdata = csr_merge(w_tcfg, csr_wdata, csr_wmask);

   csr_excp_ctrl_timer u_timer (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_tcfg_we    (w_tcfg_we),
      .i_tcfg_wdata (w_tcfg_wdata),
      .o_tcfg       (w_tcfg),
      .o_tval       (w_tval),
      .o_timer_fire (w_timer_fire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_crmd           <= CRMD_RESET;
         r_prmd           <= '0;
         r_ecfg           <= '0;
         r_estat          <= '0;
         r_era            <= '0;
         r_badv           <= '0;
         r_eentry         <= RESET_EENTRY;
         r_tlbrentry      <= RESET_TLBRENTRY;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_estat[ESTAT_IS_HW +: 8] <= hw_int;
         r_estat[ESTAT_IS_IPI]     <= ipi;
         // Software clear beats a timer fire landing on the same edge.
         if (w_ticlr) begin
            r_estat[ESTAT_IS_TI] <= 1'b0;
         end else if (w_timer_fire) begin
            r_estat[ESTAT_IS_TI] <= 1'b1;
         end
         r_redirect_valid <= w_any_flush;
         r_redirect_pc    <= '0;
         if (excp_flush) begin
            r_prmd[PRMD_PPLV +: 2]      <= r_crmd[CRMD_PLV +: 2];
            r_prmd[PRMD_PIE]            <= r_crmd[CRMD_IE];
            r_crmd[CRMD_PLV +: 2]       <= 2'b00;
            r_crmd[CRMD_IE]             <= 1'b0;
            r_era                       <= excp_era;
            r_estat[ESTAT_ECODE +: 6]   <= ecode;
            r_estat[ESTAT_ESUBCODE +: 9] <= esubcode;
            if (badv_valid) begin
               r_badv <= badv;
            end
            if (ecode == ECODE_TLBR) begin
               r_crmd[CRMD_DA] <= 1'b1;
               r_crmd[CRMD_PG] <= 1'b0;
               r_redirect_pc   <= r_tlbrentry;
            end else begin
               r_redirect_pc   <= r_eentry;
            end
         end else if (ertn_flush) begin
            r_crmd[CRMD_PLV +: 2] <= r_prmd[PRMD_PPLV +: 2];
            r_crmd[CRMD_IE]       <= r_prmd[PRMD_PIE];
            r_redirect_pc         <= r_era;
            if (r_estat[ESTAT_ECODE +: 6] == ECODE_TLBR) begin
               r_crmd[CRMD_DA] <= 1'b0;
               r_crmd[CRMD_PG] <= 1'b1;
            end
         end else if (csr_we) begin
            case (csr_waddr)
               CSR_CRMD:      r_crmd      <= csr_merge(r_crmd, csr_wdata, csr_wmask & CRMD_WMASK);
               CSR_PRMD:      r_prmd      <= csr_merge(r_prmd, csr_wdata, csr_wmask & PRMD_WMASK);
               CSR_ECFG:      r_ecfg      <= csr_merge(r_ecfg, csr_wdata, csr_wmask & ECFG_WMASK);
               CSR_ERA:       r_era       <= csr_merge(r_era, csr_wdata, csr_wmask);
               CSR_BADV:      r_badv      <= csr_merge(r_badv, csr_wdata, csr_wmask);
               CSR_EENTRY:    r_eentry    <= csr_merge(r_eentry, csr_wdata, csr_wmask & ENTRY_WMASK);
               CSR_TLBRENTRY: r_tlbrentry <= csr_merge(r_tlbrentry, csr_wdata, csr_wmask & ENTRY_WMASK);
`ifdef CSR_SOFT_INT_EN
               CSR_ESTAT:     r_estat[ESTAT_IS_SW +: 2] <=
                                 (r_estat[ESTAT_IS_SW +: 2] & ~csr_wmask[ESTAT_IS_SW +: 2]) |
                                 (csr_wdata[ESTAT_IS_SW +: 2] & csr_wmask[ESTAT_IS_SW +: 2]);
`endif
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         CSR_CRMD:      csr_rdata = r_crmd;
         CSR_PRMD:      csr_rdata = r_prmd;
         CSR_ECFG:      csr_rdata = r_ecfg;
         CSR_ESTAT:     csr_rdata = r_estat;
         CSR_ERA:       csr_rdata = r_era;
         CSR_BADV:      csr_rdata = r_badv;
         CSR_EENTRY:    csr_rdata = r_eentry;
         CSR_TLBRENTRY: csr_rdata = r_tlbrentry;
         CSR_TCFG:      csr_rdata = w_tcfg;
         CSR_TVAL:      csr_rdata = w_tval;
         default:       csr_rdata = '0;
      endcase
   end

   // IS[1:0] stay zero unless software interrupts are built in, so they drop out here.
   assign int_pending    = r_crmd[CRMD_IE] & |(r_estat[ESTAT_IS_W-1:0] & r_ecfg[ESTAT_IS_W-1:0]);
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign crmd_plv       = r_crmd[CRMD_PLV +: 2];
   assign crmd_da_pg     = {r_crmd[CRMD_DA], r_crmd[CRMD_PG]};

endmodule
